gcd_driver: RTL and testbench
=============================

# gcd_driver

Request-side sequencer for the GCD unit. Accepts operand pairs on a valid/ready input, screens out zero operands, and sends nonzero pairs to the GCD control/datapath with a one-cycle `go` pulse. It then waits for the GCD `out_en` completion pulse, with a cycle-count timeout, and returns the result on a valid/ready output. It sits between the host-side command stream and the GCD unit, and owns the GCD's `go` input and an auxiliary clear.

## Interface
Parameters:
- `WIDTH`, default 8: operand/result width.
- `TIMEOUT`, default 255: max cycles spent in WAIT before abort. Must be ≥ 4.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: driver can accept a pair.
- `in_a`, `in_b` in WIDTH: operands.
- `go` out 1: start pulse to GCD unit.
- `op_a`, `op_b` out WIDTH: registered operands driven to the GCD datapath.
- `gcd_clr` out 1: one-cycle clear pulse to the GCD unit on timeout.
- `gcd_done` in 1: GCD `out_en` (one-cycle completion pulse).
- `gcd_result` in WIDTH: GCD result, valid when `gcd_done`=1.
- `res_valid` out 1: result valid.
- `res_ready` in 1: consumer accepts result.
- `res_data` out WIDTH: result.
- `res_err` out 1: qualifies `res_data`; 1 = timeout abort, and `res_data` is then 0.
- `busy` out 1: state ≠ IDLE.

## Operation
States: IDLE, ISSUE, WAIT, FLUSH, RESP.

**IDLE**
- `in_ready`=1 (and `rst`=0).
- On `in_valid&in_ready`, register `in_a`/`in_b` into `op_a`/`op_b`.
- If both operands are nonzero → ISSUE.
- If either operand is 0, bypass the GCD (the subtractive GCD never terminates on a 0 operand). Load `res_data` = `in_a|in_b` (gcd(x,0)=x, gcd(0,0)=0), `res_err`=0 → RESP.

**ISSUE**
- `go`=1 for exactly this cycle → WAIT.
- Clear the timeout counter (width $clog2(TIMEOUT+1)).

**WAIT**
- `go`=0. The counter increments each cycle.
- If `gcd_done`=1: capture `gcd_result` → `res_data`, `res_err`=0 → RESP.
- Else if counter == TIMEOUT-1 → FLUSH.
- If `gcd_done` and the expiry condition occur together, `gcd_done` wins.

**FLUSH**
- `gcd_clr`=1 for one cycle, `res_data`=0, `res_err`=1 → RESP.

**RESP**
- `res_valid`=1. `res_data`/`res_err` are held stable until `res_valid&res_ready`, then → IDLE.
- `gcd_done` is ignored in every state except WAIT.

General rules:
- `op_a`/`op_b` change only on input acceptance. They stay stable from ISSUE through the exit from WAIT.
- Reset mid-operation (any state): next state IDLE. Pending result is discarded and the counter cleared. `gcd_clr` is not pulsed because the system reset also resets the GCD.
- All outputs are registered or decoded from state only, with no combinational path from any input to any output.

## Timing
Reset values:
- `go`=0, `gcd_clr`=0, `res_valid`=0, `res_err`=0, `busy`=0.
- `res_data`=0, `op_a`=0, `op_b`=0.
- `in_ready`=0 while `rst`=1, then 1 in IDLE.

Latencies:
- Accept edge → `go` high the next cycle.
- `gcd_done` sampled at edge N → `res_valid` high from cycle N+1.
- Zero bypass: accept edge → `res_valid` the next cycle.
- Timeout: `go` at cycle 0 → FLUSH at cycle TIMEOUT+1 → `res_valid` at cycle TIMEOUT+2.

Throughput:
- At most one pair in flight. `in_ready` is low from acceptance until the cycle after the result handshake.
- Back-to-back: `res_ready` held at 1 gives one RESP cycle, then IDLE.

Handshakes:
- Standard valid/ready; transfer occurs on the edge where both are 1.
- The consumer may stall `res_ready` indefinitely with no data loss.

## Test plan
- **Basic:** reset, then `in_a`=12, `in_b`=18 against the GCD unit model. Expect one `go` pulse, then `res_valid` with `res_data`=6, `res_err`=0. `res_valid` rises exactly one cycle after `gcd_done`.
- **Equal operands and back-to-back:** `in_a`=`in_b`=9, then `in_a`=35, `in_b`=14 with `res_ready` tied 1. Expect results 9 then 7. `in_ready` is low throughout each transaction, and exactly one `go` is issued per pair.
- **Zero bypass:** pairs (0,5), (7,0), (0,0). Expect results 5, 7, 0 each one cycle after acceptance. `go` never asserts.
- **Timeout:** `TIMEOUT`=8, `gcd_done` held 0. Expect FLUSH with `gcd_clr` pulsed once, then `res_valid` with `res_err`=1 and `res_data`=0. Also drive `gcd_done` on the final WAIT cycle: expect a normal result and no `gcd_clr`.
- **Backpressure:** hold `res_ready`=0 for 20 cycles after a result. `res_data` and `res_err` stay stable, `in_ready` stays 0, and a stray `gcd_done` pulse has no effect.
- **Reset mid-operation:** assert `rst` in WAIT and again in RESP. Next cycle all outputs are at reset values. After `rst` drops, a new pair (24,36) → 12.

Source files
------------

// File: rtl/gcd_driver_if.sv
// Host-side operand and result streams of the GCD request sequencer.
// The host owns the master side; gcd_driver owns the slave side.
interface gcd_driver_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_err;

    modport master (
        output in_valid, in_a, in_b, res_ready,
        input  in_ready, res_valid, res_data, res_err
    );

    modport slave (
        input  in_valid, in_a, in_b, res_ready,
        output in_ready, res_valid, res_data, res_err
    );
endinterface

// File: rtl/gcd_driver.sv
// Request-side sequencer for the GCD unit: screens zero operands, issues go,
// waits for completion with a timeout and returns the result on a valid/ready stream.
//
// state | meaning
// IDLE  | ready for an operand pair
// ISSUE | go pulse to the GCD unit, timeout counter cleared
// WAIT  | waiting for gcd_done, counting towards TIMEOUT
// FLUSH | timeout abort, gcd_clr pulse, error result loaded
// RESP  | result presented until res_ready
module gcd_driver #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    gcd_driver_if.slave      bus,
    output logic             go,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             gcd_clr,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_result,
    output logic             busy
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FLUSH, RESP} state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] res_data_q;
    logic             res_err_q;
    logic             operand_zero;

    // The subtractive GCD never terminates on a zero operand, so such pairs bypass it.
    assign operand_zero = (bus.in_a == '0) || (bus.in_b == '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = operand_zero ? RESP : ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT: begin
                if (gcd_done)             state_next = RESP;
                else if (cnt == CNT_LAST) state_next = FLUSH;
            end
            FLUSH:   state_next = RESP;
            RESP:    if (bus.res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a       <= '0;
            op_b       <= '0;
            cnt        <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_a <= bus.in_a;
                        op_b <= bus.in_b;
                        if (operand_zero) begin
                            res_data_q <= bus.in_a | bus.in_b;
                            res_err_q  <= 1'b0;
                        end
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (gcd_done) begin
                        res_data_q <= gcd_result;
                        res_err_q  <= 1'b0;
                    end
                end
                FLUSH: begin
                    res_data_q <= '0;
                    res_err_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign go            = (state == ISSUE);
    assign gcd_clr       = (state == FLUSH);
    assign busy          = (state != IDLE);
    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.res_valid = (state == RESP);
    assign bus.res_data  = res_data_q;
    assign bus.res_err   = res_err_q;
endmodule

// File: tb/tb_gcd_driver.sv
// Bench for gcd_driver: table vectors, random pairs against a Euclid reference,
// and hand-written reset-during-operation sequences.
module tb_gcd_driver;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             go;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             gcd_clr;
    logic             gcd_done = 1'b0;
    logic [WIDTH-1:0] gcd_result = '0;
    logic             busy;

    int errors = 0;
    int checks = 0;

    gcd_driver_if #(.WIDTH(WIDTH)) bus ();

    gcd_driver #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .go         (go),
        .op_a       (op_a),
        .op_b       (op_b),
        .gcd_clr    (gcd_clr),
        .gcd_done   (gcd_done),
        .gcd_result (gcd_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int               lat;
        int               stall;
        logic [WIDTH-1:0] exp_d;
        bit               exp_e;
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] gcd_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_go"},        go,            0);
        chk({tag, "_gcd_clr"},   gcd_clr,       0);
        chk({tag, "_res_valid"}, bus.res_valid, 0);
        chk({tag, "_res_err"},   bus.res_err,   0);
        chk({tag, "_busy"},      busy,          0);
        chk({tag, "_res_data"},  bus.res_data,  0);
        chk({tag, "_op_a"},      op_a,          0);
        chk({tag, "_op_b"},      op_b,          0);
        chk({tag, "_in_ready"},  bus.in_ready,  0);
    endtask

    // Drives one pair through, playing the GCD unit with a completion latency of v.lat
    // WAIT cycles (no completion at all when v.lat exceeds TIMEOUT).
    task automatic do_pair(input vec_t v);
        int  n;
        int  gos;
        int  clrs;
        bit  zero;
        logic [WIDTH-1:0] held_d;
        logic             held_e;
        zero = (v.a == 0) || (v.b == 0);
        gos  = 0;
        clrs = 0;
        n    = 0;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        chk("in_ready_idle", bus.in_ready, 1);
        bus.in_valid  = 1'b1;
        bus.in_a      = v.a;
        bus.in_b      = v.b;
        bus.res_ready = (v.stall == 0);
        step();
        bus.in_valid = 1'b0;
        bus.in_a     = WIDTH'($urandom);
        bus.in_b     = WIDTH'($urandom);
        gcd_result   = WIDTH'($urandom);
        gos += int'(go);
        clrs += int'(gcd_clr);
        chk("in_ready_busy", bus.in_ready, 0);
        if (zero) begin
            chk("bypass_valid", bus.res_valid, 1);
        end else begin
            chk("go_after_accept", go, 1);
            chk("op_a_reg", op_a, v.a);
            chk("op_b_reg", op_b, v.b);
            for (int w = 1; w <= TIMEOUT; w++) begin
                step();
                gos += int'(go);
                clrs += int'(gcd_clr);
                chk("wait_no_valid", bus.res_valid, 0);
                chk("wait_in_ready", bus.in_ready, 0);
                chk("op_a_stable", op_a, v.a);
                chk("op_b_stable", op_b, v.b);
                if (w == v.lat) begin
                    gcd_done   = 1'b1;
                    gcd_result = gcd_ref(v.a, v.b);
                    step();
                    gcd_done   = 1'b0;
                    gcd_result = WIDTH'($urandom);
                    gos += int'(go);
                    clrs += int'(gcd_clr);
                    chk("valid_after_done", bus.res_valid, 1);
                    break;
                end
            end
            if (v.lat > TIMEOUT) begin
                step();
                gos += int'(go);
                clrs += int'(gcd_clr);
                chk("flush_clr", gcd_clr, 1);
                chk("flush_no_valid", bus.res_valid, 0);
                step();
                gos += int'(go);
                clrs += int'(gcd_clr);
                chk("timeout_valid", bus.res_valid, 1);
            end
        end
        chk("res_data", bus.res_data, v.exp_d);
        chk("res_err", bus.res_err, v.exp_e);
        held_d = bus.res_data;
        held_e = bus.res_err;
        for (int s = 0; s < v.stall; s++) begin
            if (s == 0) begin
                gcd_done   = 1'b1;
                gcd_result = ~v.exp_d;
            end
            step();
            gcd_done = 1'b0;
            gos += int'(go);
            clrs += int'(gcd_clr);
            chk("stall_valid", bus.res_valid, 1);
            chk("stall_data", bus.res_data, held_d);
            chk("stall_err", bus.res_err, held_e);
            chk("stall_in_ready", bus.in_ready, 0);
        end
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        chk("post_hs_in_ready", bus.in_ready, 1);
        chk("post_hs_busy", busy, 0);
        chk("post_hs_valid", bus.res_valid, 0);
        chk("go_count", gos, zero ? 0 : 1);
        chk("clr_count", clrs, v.exp_e ? 1 : 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   n;
        vecs[0] = '{a: 12, b: 18, lat: 3,  stall: 1,  exp_d: 6,  exp_e: 0};
        vecs[1] = '{a: 9,  b: 9,  lat: 1,  stall: 0,  exp_d: 9,  exp_e: 0};
        vecs[2] = '{a: 35, b: 14, lat: 5,  stall: 0,  exp_d: 7,  exp_e: 0};
        vecs[3] = '{a: 0,  b: 5,  lat: 1,  stall: 0,  exp_d: 5,  exp_e: 0};
        vecs[4] = '{a: 7,  b: 0,  lat: 1,  stall: 1,  exp_d: 7,  exp_e: 0};
        vecs[5] = '{a: 0,  b: 0,  lat: 1,  stall: 0,  exp_d: 0,  exp_e: 0};
        vecs[6] = '{a: 20, b: 30, lat: 99, stall: 1,  exp_d: 0,  exp_e: 1};
        vecs[7] = '{a: 20, b: 30, lat: 8,  stall: 0,  exp_d: 10, exp_e: 0};
        vecs[8] = '{a: 48, b: 18, lat: 2,  stall: 20, exp_d: 6,  exp_e: 0};
        vecs[9] = '{a: 0,  b: 77, lat: 1,  stall: 20, exp_d: 77, exp_e: 0};

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.res_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        check_reset("reset");
        rst = 1'b0;
        #1;
        chk("in_ready_after_reset", bus.in_ready, 1);

        for (int i = 0; i < 10; i++) do_pair(vecs[i]);

        for (int i = 0; i < 30; i++) begin
            v.a     = ($urandom_range(0, 4) == 0) ? '0 : WIDTH'($urandom);
            v.b     = ($urandom_range(0, 4) == 0) ? '0 : WIDTH'($urandom);
            v.lat   = $urandom_range(1, 10);
            v.stall = $urandom_range(0, 3);
            v.exp_e = (v.a != 0) && (v.b != 0) && (v.lat > TIMEOUT);
            v.exp_d = v.exp_e ? '0 : gcd_ref(v.a, v.b);
            do_pair(v);
        end

        // Reset while waiting on the GCD unit.
        n = 0;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        bus.in_valid = 1'b1;
        bus.in_a     = 24;
        bus.in_b     = 36;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        chk("mid_wait_busy", busy, 1);
        rst = 1'b1;
        step();
        check_reset("rst_in_wait");
        rst = 1'b0;
        #1;
        chk("in_ready_after_wait_rst", bus.in_ready, 1);

        // Reset while a result is pending.
        bus.in_valid = 1'b1;
        bus.in_a     = 0;
        bus.in_b     = 9;
        step();
        bus.in_valid = 1'b0;
        chk("resp_pending_data", bus.res_data, 9);
        step();
        rst = 1'b1;
        step();
        check_reset("rst_in_resp");
        rst = 1'b0;
        #1;
        chk("in_ready_after_resp_rst", bus.in_ready, 1);

        v = '{a: 24, b: 36, lat: 3, stall: 1, exp_d: 12, exp_e: 0};
        do_pair(v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
